// File: rtl/conv_tile_fetch.sv
// Tile fetcher: walks a greyscale frame in 16-bit image SRAM and issues overlapping 4x4 tiles
// at stride 2 to the conv stage. Define CONV_TILE_FETCH_PREFETCH_EN to overlap fetch with conv work.
module conv_tile_fetch #(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_rdata,
   output logic [127:0]      image_4x4,
   output logic              input_re,
   output logic [15:0]       input_addr,
   input  logic              conv_done,
   output logic              busy,
   output logic              frame_done
);

   localparam int TILES_X = IMG_W / 2 - 1;
   localparam int TILES_Y = IMG_H / 2 - 1;
   localparam int N_TILES = TILES_X * TILES_Y;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT1,
      READY,
      ISSUE,
      BLOCK,
      DRAIN
   } state_e;

   state_e            state_q, state_d;

   logic [ADDR_W-1:0] base_q;
   logic [15:0]       row_q;       // top pixel row r of the tile being fetched
   logic [15:0]       col2_q;      // left column c of that tile, in pixel pairs (c/2)
   logic [15:0]       idx_q;
   logic [2:0]        j_q;
   logic              rd_valid_q;
   logic [2:0]        rd_j_q;
   logic [127:0]      asm_q;
   logic              conv_busy_q;

   logic [127:0]      image_q;
   logic              input_re_q;
   logic [15:0]       input_addr_q;
   logic              busy_q;
   logic              frame_done_q;

   logic              conv_free;
   logic              start_fire;
   logic              issue_fire;
   logic              drain_fire;
   logic              last_issued;
   logic              last_col;
   logic [ADDR_W-1:0] fetch_off;

   // A same-cycle conv_done frees the conv stage for an issue this cycle (bypass).
   assign conv_free   = conv_done | ~conv_busy_q;
   assign start_fire  = (state_q == IDLE) & start;
   assign issue_fire  = (state_q == READY) & conv_free;
   assign drain_fire  = (state_q == DRAIN) & conv_free;
   assign last_issued = (idx_q == 16'(N_TILES));
   assign last_col    = (col2_q == 16'(TILES_X - 1));

   assign fetch_off = ADDR_W'((32'(row_q) + 32'(j_q[2:1])) * 32'(IMG_W / 2)
                              + 32'(col2_q) + 32'(j_q[0]));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every comb output gets a default first so no path can leave it unassigned (latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   if (j_q == 3'd7) state_d = WAIT1;
         WAIT1:   state_d = READY;
         READY:   if (conv_free) state_d = ISSUE;
         ISSUE: begin
            if (last_issued) begin
               state_d = DRAIN;
            end else begin
`ifdef CONV_TILE_FETCH_PREFETCH_EN
               state_d = FETCH;
`else
               state_d = BLOCK;
`endif
            end
         end
         BLOCK:   if (conv_free) state_d = FETCH;
         DRAIN:   if (conv_free) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_re   = 1'b0;
      mem_addr = '0;
      if (state_q == FETCH) begin
         mem_re   = 1'b1;
         mem_addr = base_q + fetch_off;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q       <= '0;
         row_q        <= '0;
         col2_q       <= '0;
         idx_q        <= '0;
         j_q          <= '0;
         rd_valid_q   <= 1'b0;
         rd_j_q       <= '0;
         conv_busy_q  <= 1'b0;
         image_q      <= '0;
         input_re_q   <= 1'b0;
         input_addr_q <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         j_q        <= (state_q == FETCH) ? j_q + 3'd1 : 3'd0;
         rd_valid_q <= (state_q == FETCH);
         rd_j_q     <= j_q;
         input_re_q   <= issue_fire;
         frame_done_q <= drain_fire;

         if (start_fire) begin
            base_q <= base_addr;
            row_q  <= '0;
            col2_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b1;
         end else if (drain_fire) begin
            busy_q <= 1'b0;
         end

         if (issue_fire) begin
            image_q      <= asm_q;
            input_addr_q <= idx_q;
            idx_q        <= idx_q + 16'd1;
            if (last_col) begin
               col2_q <= '0;
               row_q  <= row_q + 16'd2;
            end else begin
               col2_q <= col2_q + 16'd1;
            end
         end

         if (issue_fire) begin
            conv_busy_q <= 1'b1;
         end else if (conv_done) begin
            conv_busy_q <= 1'b0;
         end
      end
   end

   // NOTE: the assembly buffer has no reset; all 8 words are rewritten before any issue reads it.
   always_ff @(posedge clk) begin
      if (rd_valid_q) begin
         asm_q[{rd_j_q, 4'b0000} +: 16] <= mem_rdata;
      end
   end

   assign image_4x4  = image_q;
   assign input_re   = input_re_q;
   assign input_addr = input_addr_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_tile_fetch.sv
// Self-checking bench for conv_tile_fetch on an 8x8 frame: address/tile scoreboard plus
// conv-stage responder; honours CONV_TILE_FETCH_PREFETCH_EN for timing expectations.
module tb_conv_tile_fetch;

   localparam int W       = 8;
   localparam int H       = 8;
   localparam int AW      = 16;
   localparam int N_TILES = 9;
`ifdef CONV_TILE_FETCH_PREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif
   localparam int GAP = PF ? 1 : 11;

   typedef struct {
      logic [15:0]  idx;
      logic [127:0] data;
   } exp_tile_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          mem_re;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_rdata = '0;
   logic [127:0]  image_4x4;
   logic          input_re;
   logic [15:0]   input_addr;
   logic          conv_done = 1'b0;
   logic          busy;
   logic          frame_done;

   conv_tile_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .mem_re     (mem_re),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .image_4x4  (image_4x4),
      .input_re   (input_re),
      .input_addr (input_addr),
      .conv_done  (conv_done),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // SRAM holding pixel(r,c) = r*8+c from word 0x0100 on; one-cycle read latency.
   logic [15:0] sram_off;
   assign sram_off = mem_addr - 16'h0100;
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= {sram_off[6:0], 1'b1, sram_off[6:0], 1'b0};
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   exp_tile_t     tile_q[$];
   logic [15:0]   addr_q[$];
   int            delay = 0;
   bit            manual = 1'b0;
   bit            pulse_req = 1'b0;
   int            cnt = 0;
   bit            outst = 1'b0;
   int            start_cyc = 0;
   int            tile_no = 0;
   int            mem_re_cnt = 0;
   int            last_mem_cyc = 0;
   int            last_done_cyc = 0;
   int            fd_count = 0;
   int            addr_cnt = 0;
   bit            first_mem_pending = 1'b0;
   bit            prev_input_re = 1'b0;
   bit            prev_busy = 1'b0;
   int            consec_viol = 0;
   int            overlap_cnt = 0;
   logic [127:0]  seen_tile [N_TILES];
   logic [15:0]   tile0_addr [8];
   bit            mon_fire;
   logic [15:0]   mon_a;
   exp_tile_t     mon_e;

   function automatic logic [127:0] tile_model(input int r, input int c);
      logic [127:0] t;
      t = '0;
      for (int ky = 0; ky < 4; ky++)
         for (int kx = 0; kx < 4; kx++)
            t[ky*32 + kx*8 +: 8] = 8'((r + ky) * W + c + kx);
      return t;
   endfunction

   // Monitor + conv-stage responder: samples outputs and drives conv_done on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            conv_done     = 1'b0;
            cnt           = 0;
            outst         = 1'b0;
            pulse_req     = 1'b0;
            prev_input_re = 1'b0;
            prev_busy     = 1'b0;
         end else begin
            mon_fire = 1'b0;
            if (conv_done) outst = 1'b0;
            if (mem_re) begin
               mem_re_cnt++;
               last_mem_cyc = cyc;
               if (outst) overlap_cnt++;
               if (first_mem_pending) begin
                  check("mem_re_latency", 128'(cyc), 128'(start_cyc + 1));
                  first_mem_pending = 1'b0;
               end
               if (addr_q.size() == 0) begin
                  check("addr_q_size", 128'(addr_q.size()), 128'(1));
               end else begin
                  mon_a = addr_q.pop_front();
                  check("mem_addr", 128'(mem_addr), 128'(mon_a));
               end
               if (addr_cnt < 8) tile0_addr[addr_cnt] = mem_addr;
               addr_cnt++;
            end
            if (input_re && prev_input_re) consec_viol++;
            if (!manual && cnt > 0) begin
               cnt--;
               if (cnt == 0) mon_fire = 1'b1;
            end
            if (input_re) begin
               if (tile_no == 0) check("issue_latency", 128'(cyc), 128'(start_cyc + 11));
               else check("issue_gap", 128'(cyc), 128'(last_done_cyc + GAP));
               if (tile_q.size() == 0) begin
                  check("tile_q_size", 128'(tile_q.size()), 128'(1));
               end else begin
                  mon_e = tile_q.pop_front();
                  check("tile_idx", 128'(input_addr), 128'(mon_e.idx));
                  check("tile_data", image_4x4, mon_e.data);
               end
               if (input_addr < 16'(N_TILES)) seen_tile[input_addr[3:0]] = image_4x4;
               tile_no++;
               outst = 1'b1;
               cnt   = delay;
            end
            if (frame_done) begin
               fd_count++;
               check("frame_done_latency", 128'(cyc), 128'(last_done_cyc + 1));
               check("busy_drop", 128'({prev_busy, busy}), 128'(2'b10));
            end
            if (manual && pulse_req) begin
               mon_fire  = 1'b1;
               pulse_req = 1'b0;
            end
            conv_done = mon_fire;
            if (mon_fire) last_done_cyc = cyc;
            prev_input_re = input_re;
            prev_busy     = busy;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic start_frame(input int dly, input bit man);
      exp_tile_t e;
      tick();
      addr_q.delete();
      tile_q.delete();
      for (int t = 0; t < N_TILES; t++) begin
         int r;
         int c;
         r = (t / 3) * 2;
         c = (t % 3) * 2;
         e.idx  = 16'(t);
         e.data = tile_model(r, c);
         tile_q.push_back(e);
         for (int j = 0; j < 8; j++)
            addr_q.push_back(16'(16'h0100 + ((r + j / 2) * W + c) / 2 + j % 2));
      end
      delay             = dly;
      manual            = man;
      cnt               = 0;
      tile_no           = 0;
      mem_re_cnt        = 0;
      addr_cnt          = 0;
      first_mem_pending = 1'b1;
      start_cyc         = cyc;
      start             = 1'b1;
      base_addr         = 16'h0100;
      tick();
      start             = 1'b0;
   endtask

   task automatic pulse_start_ignored();
      start     = 1'b1;
      base_addr = 16'h0200;
      tick();
      start     = 1'b0;
      base_addr = 16'h0100;
   endtask

   task automatic wait_frame(input int budget);
      int fd0;
      int n;
      fd0 = fd_count;
      n   = 0;
      while (fd_count == fd0 && n < budget) begin
         tick();
         n++;
      end
      check("frame_done_seen", 128'(fd_count - fd0), 128'(1));
   endtask

   task automatic post_frame_checks();
      check("tiles_issued", 128'(tile_no), 128'(N_TILES));
      check("addr_q_left", 128'(addr_q.size()), 128'(0));
      check("tile_q_left", 128'(tile_q.size()), 128'(0));
      check("busy_after_frame", 128'(busy), 128'(0));
   endtask

   task automatic clear_after_reset();
      addr_q.delete();
      tile_q.delete();
      first_mem_pending = 1'b0;
   endtask

   logic [15:0] exp_a0 [8] = '{16'h0100, 16'h0101, 16'h0104, 16'h0105,
                               16'h0108, 16'h0109, 16'h010C, 16'h010D};

   initial begin
      int s;
      repeat (3) tick();
      check("reset_image", image_4x4, 128'(0));
      check("reset_ctrl", 128'({mem_re, mem_addr, input_re, input_addr, busy, frame_done}), 128'(0));
      rst = 1'b0;
      repeat (2) tick();

      // Full frame, conv_done 38 cycles after each tile, with ignored mid-frame start pulses.
      start_frame(38, 1'b0);
      s = start_cyc;
      wait_until(s + 5);
      pulse_start_ignored();
      wait_until(s + 100);
      pulse_start_ignored();
      wait_frame(2000);
      post_frame_checks();
      check("tile0_const", seen_tile[0], 128'h1B1A1918_13121110_0B0A0908_03020100);
      check("tile1_row0", 128'(seen_tile[1][31:0]), 128'(32'h05040302));
      check("tile3_row0", 128'(seen_tile[3][31:0]), 128'(32'h13121110));
      for (int i = 0; i < 8; i++) check("tile0_addr", 128'(tile0_addr[i]), 128'(exp_a0[i]));
      repeat (3) tick();

      // Reset mid-FETCH of tile 0, then replay with conv_done landing on READY entry.
      start_frame(10, 1'b0);
      s = start_cyc;
      wait_until(s + 5);
      rst = 1'b1;
      tick();
      check("rst5_image", image_4x4, 128'(0));
      check("rst5_ctrl", 128'({mem_re, mem_addr, input_re, input_addr, busy, frame_done}), 128'(0));
      rst = 1'b0;
      clear_after_reset();
      tick();
      check("idle_after_rst", 128'({mem_re, busy, input_re}), 128'(0));
      start_frame(10, 1'b0);
      wait_frame(2000);
      post_frame_checks();
      repeat (3) tick();

      // conv_done withheld after tile 0, then released for one cycle.
      start_frame(0, 1'b1);
      s = start_cyc;
      wait_until(s + 60);
      check("hold_issues", 128'(tile_no), 128'(1));
      check("hold_mem_cnt", 128'(mem_re_cnt), 128'(PF ? 16 : 8));
      check("hold_last_mem", 128'(last_mem_cyc), 128'(s + (PF ? 19 : 8)));
      check("hold_busy", 128'(busy), 128'(1));
      pulse_req = 1'b1;
      repeat (16) tick();
      check("release_issues", 128'(tile_no), 128'(2));
      rst = 1'b1;
      tick();
      check("rst_mid_image", image_4x4, 128'(0));
      check("rst_mid_ctrl", 128'({mem_re, mem_addr, input_re, input_addr, busy, frame_done}), 128'(0));
      rst = 1'b0;
      clear_after_reset();
      repeat (2) tick();

      check("input_re_back_to_back", 128'(consec_viol), 128'(0));
      check("mem_re_during_busy", 128'(overlap_cnt != 0), 128'(PF));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required to finish earlier", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/conv_tile_fetch.md
# conv_tile_fetch

Upstream feeder for the 3×3-conv / 2×2-max-pool stage. Walks a greyscale frame stored in a 16-bit-wide image SRAM and assembles overlapping 4×4 pixel tiles at stride 2. Presents each tile as a 128-bit word with a one-cycle `input_re` strobe and a tile index on `input_addr`. Throttles on the conv stage's completion strobe, so a tile is never issued while the previous one is still being processed.

## Interface
- `IMG_W`, default 32: frame width in pixels; even, ≥4.
- `IMG_H`, default 32: frame height in pixels; even, ≥4.
- `ADDR_W`, default 16: SRAM word-address width.

- `clk` in 1: the only clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: frame start pulse; sampled only in IDLE.
- `base_addr` in ADDR_W: SRAM word address of pixel (0,0); captured on accepted `start`.
- `mem_re` out 1: SRAM read enable.
- `mem_addr` out ADDR_W: SRAM word address.
- `mem_rdata` in 16: read data, valid the cycle after `mem_re`. [7:0] holds the even (left) column, [15:8] the odd column.
- `image_4x4` out 128: tile; row ky at [ky*32 +: 32], column kx at byte kx within the row.
- `input_re` out 1: one-cycle tile-valid strobe.
- `input_addr` out 16: tile index, raster order from 0.
- `conv_done` in 1: conv stage finished a tile; connects to its write-enable.
- `busy` out 1: high from accepted `start` until `frame_done`.
- `frame_done` out 1: one-cycle pulse after the last tile completes.

## Operation
- Tile (r,c) covers rows r..r+3 and columns c..c+3.
  - c steps 0,2,…,IMG_W-4; it then wraps to 0 and r += 2, up to IMG_H-4.
  - The frame holds (IMG_W/2-1)*(IMG_H/2-1) tiles.
- Fetch issues 8 reads, j=0..7, on consecutive cycles.
  - Address: base + ((r + j/2)*IMG_W + c)/2 + (j%2).
  - Data fills assembly-buffer row j/2, bytes 2*(j%2) and 2*(j%2)+1.
- States:
  - IDLE: `start` → FETCH with tile (0,0).
  - FETCH: 8 read cycles, then WAIT1.
  - WAIT1: captures the last word, then READY.
  - READY: issue condition met → ISSUE; otherwise hold.
  - ISSUE: the last tile → DRAIN; otherwise → FETCH for the next tile, or → BLOCK when prefetch is disabled.
  - BLOCK: waits for `conv_done`, then → FETCH.
  - DRAIN: waits for `conv_done`, pulses `frame_done`, then → IDLE.
- Issue condition: `conv_busy==0` or `conv_done==1` in the same cycle (bypass).
- Issue action, registered:
  - `image_4x4` ← assembly buffer.
  - `input_re` ← 1.
  - `input_addr` ← tile index.
  - `conv_busy` ← 1.
- `conv_busy` clears on `conv_done` unless an issue occurs in that cycle.
- `image_4x4` and `input_addr` hold until the next issue. The assembly buffer may be overwritten freely after issue.
- `start` outside IDLE is ignored.
- `conv_done` while `conv_busy==0` is ignored.
- `rst` mid-frame aborts immediately; the next cycle is IDLE with no residual strobes.

## Timing
- Every output resets to 0.
- Cycle numbering: `start` accepted at cycle 0.
  - `mem_re` is high in cycles 1–8.
  - The first `input_re` is high in cycle 11, provided `conv_busy==0`.
- With prefetch, the next tile's reads run in cycles 12–19 and it is ready to issue in cycle 21.
- `input_re` is never high on two consecutive cycles.
- At most one tile is outstanding at the conv stage.
- `frame_done` fires the cycle after `conv_done` for the last tile, i.e. the clock edge on which DRAIN sees `conv_done`. `busy` drops with it.

## Configuration
- `CONV_TILE_FETCH_PREFETCH_EN` defined: the fetch of tile n+1 starts in the cycle after the issue of tile n and overlaps conv processing.
- Undefined: after ISSUE the FSM enters BLOCK. No `mem_re` occurs while `conv_busy==1`, and throughput drops by about 10 cycles per tile.

## Test plan
All scenarios use IMG_W=IMG_H=8, base_addr=0x0100, and SRAM pixel(r,c)=r*8+c. That gives 9 tiles.

- Frame with `conv_done` returned 38 cycles after each `input_re`:
  - 9 strobes with input_addr 0..8.
  - Tile 0 = 128'h1B1A1918_13121110_0B0A0908_03020100.
  - Tile 1 row0 = 32'h05040302.
  - Tile 3 row0 = 32'h13121110.
  - Tile 0 addresses 0x0100,0x0101,0x0104,0x0105,0x0108,0x0109,0x010C,0x010D.
  - `frame_done` is 1 cycle after the 9th `conv_done`.
- `conv_done` withheld after tile 0:
  - Fetcher sits in READY; no second `input_re`; `mem_re` stays low after cycle 19.
  - Releasing `conv_done` for one cycle → `input_re` for tile 1 on the next cycle.
- `conv_done` arriving in the same cycle the fetcher enters READY:
  - Tile issued the following cycle (bypass); `conv_busy` stays 1.
- `start` pulsed again mid-frame:
  - Ignored; address sequence and tile indices unchanged.
- `rst` asserted in cycle 5 (mid-FETCH):
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - A new `start` replays from tile 0 with identical addresses.
- Macro undefined:
  - `mem_re` never coincides with `conv_busy`.
  - Tile 1's `input_re` comes exactly 11 cycles after tile 0's `conv_done`.
